// File: rtl/timer_display_if.sv
// Connection bundle between the MM:SS countdown timer and its 7-segment display driver.
// The timer side drives the BCD digits and the finished flag; the display side drives the scan outputs.
interface timer_display_if;
   logic [3:0] sec_unit;
   logic [3:0] sec_tens;
   logic [3:0] min_unit;
   logic [3:0] min_tens;
   logic       finished;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output sec_unit, sec_tens, min_unit, min_tens, finished,
      input  an, seg, dp
   );

   modport slave (
      input  sec_unit, sec_tens, min_unit, min_tens, finished,
      output an, seg, dp
   );
endinterface

// File: rtl/timer_display.sv
// Four-digit multiplexed active-low 7-segment driver for the MM:SS countdown timer, snapshotting once per frame.
// Optional blink-on-finish machine is built only when TIMER_DISPLAY_BLINK_EN is defined.
module timer_display #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 100
) (
   input  logic           clk,
   input  logic           rst,
   timer_display_if.slave bus
);

   localparam int              CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       idx_r;
   logic [3:0]       snap_st_r;
   logic [3:0]       snap_mu_r;
   logic [3:0]       snap_mt_r;
   logic [3:0]       an_r;
   logic [6:0]       seg_r;
   logic             dp_r;

   logic             tick_s;
   logic             frame_start_s;
   logic [1:0]       idx_nxt_s;
   logic [3:0]       digit_s;
   logic [3:0]       an_nxt_s;
   logic             blank_s;

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] pat;
      case (bcd)
         4'd0:    pat = 7'b1000000;
         4'd1:    pat = 7'b1111001;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         default: pat = 7'b0111111;
      endcase
      return pat;
   endfunction

   // Slot tick, frame start and the index about to be shown.
   always_comb begin
      tick_s        = (cnt_r == CNT_MAX);
      frame_start_s = tick_s && (idx_r == 2'd3);
      idx_nxt_s     = idx_r + 2'd1;
   end

   // Digit source for the upcoming slot; slot 0 is loaded on the snapshot edge, so it reads the live input.
   always_comb begin
      digit_s  = 4'hF;
      an_nxt_s = 4'b1111;
      case (idx_nxt_s)
         2'd0: begin
            digit_s  = bus.sec_unit;
            an_nxt_s = 4'b1110;
         end
         2'd1: begin
            digit_s  = snap_st_r;
            an_nxt_s = 4'b1101;
         end
         2'd2: begin
            digit_s  = snap_mu_r;
            an_nxt_s = 4'b1011;
         end
         2'd3: begin
            digit_s  = snap_mt_r;
            an_nxt_s = 4'b0111;
         end
         default: begin
            digit_s  = 4'hF;
            an_nxt_s = 4'b1111;
         end
      endcase
   end

`ifdef TIMER_DISPLAY_BLINK_EN
   localparam int              FC_W   = $clog2(BLINK_DIV + 1);
   localparam logic [FC_W-1:0] FC_MAX = FC_W'(BLINK_DIV);

   logic [FC_W-1:0] fc_r;
   logic            phase_r;
   logic [FC_W-1:0] fc_nxt_s;
   logic            phase_nxt_s;

   // Blink state for the frame being started; the finished value captured on this edge decides it.
   always_comb begin
      fc_nxt_s    = fc_r;
      phase_nxt_s = phase_r;
      if (frame_start_s) begin
         if (!bus.finished) begin
            fc_nxt_s    = {FC_W{1'b0}};
            phase_nxt_s = 1'b0;
         end else if (fc_r == FC_MAX) begin
            fc_nxt_s    = FC_W'(1);
            phase_nxt_s = ~phase_r;
         end else begin
            fc_nxt_s    = fc_r + FC_W'(1);
            phase_nxt_s = phase_r;
         end
      end else begin
         fc_nxt_s    = fc_r;
         phase_nxt_s = phase_r;
      end
   end

   // Frame counter and blink phase registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fc_r    <= {FC_W{1'b0}};
         phase_r <= 1'b0;
      end else begin
         fc_r    <= fc_nxt_s;
         phase_r <= phase_nxt_s;
      end
   end

   assign blank_s = phase_nxt_s;
`else
   localparam int unused_blink_div = BLINK_DIV;
   logic unused_finished_s;

   assign unused_finished_s = bus.finished;
   assign blank_s           = 1'b0;
`endif

   // Prescaler, scan index, per-frame snapshot and registered display outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         idx_r     <= 2'd3;
         snap_st_r <= 4'd0;
         snap_mu_r <= 4'd0;
         snap_mt_r <= 4'd0;
         an_r      <= 4'b1111;
         seg_r     <= 7'b1111111;
         dp_r      <= 1'b1;
      end else begin
         if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= idx_nxt_s;
            an_r  <= blank_s ? 4'b1111 : an_nxt_s;
            seg_r <= seg_decode(digit_s);
            dp_r  <= ((idx_nxt_s == 2'd2) && !blank_s) ? 1'b0 : 1'b1;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            idx_r <= idx_r;
            an_r  <= an_r;
            seg_r <= seg_r;
            dp_r  <= dp_r;
         end
         // The seconds-units snapshot is the seg register itself, loaded on this same edge.
         if (frame_start_s) begin
            snap_st_r <= bus.sec_tens;
            snap_mu_r <= bus.min_unit;
            snap_mt_r <= bus.min_tens;
         end else begin
            snap_st_r <= snap_st_r;
            snap_mu_r <= snap_mu_r;
            snap_mt_r <= snap_mt_r;
         end
      end
   end

   assign bus.an  = an_r;
   assign bus.seg = seg_r;
   assign bus.dp  = dp_r;

endmodule

// File: tb/tb_timer_display.sv
// Self-checking bench for timer_display: frame vectors feed a scoreboard of per-slot expectations.
// Blink expectations follow TIMER_DISPLAY_BLINK_EN; without it, finished must never blank the display.
module tb_timer_display;

   localparam int SD = 4;
   localparam int BD = 2;
`ifdef TIMER_DISPLAY_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   typedef struct {
      logic [3:0] mt, mu, st, su;
      logic [6:0] s_mt, s_mu, s_st, s_su;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      bit         care_seg;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t prev;
   exp_t blank_e;
   vec_t vecs[5];

   timer_display_if dif();

   timer_display #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   always #5 clk = ~clk;

   task automatic check_out(input string nm, input exp_t e);
      checks++;
      if (dif.an !== e.an || dif.dp !== e.dp || (e.care_seg && dif.seg !== e.seg)) begin
         errors++;
         $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b (seg checked=%0d) at %0t",
                  nm, dif.an, dif.seg, dif.dp, e.an, e.seg, e.dp, e.care_seg, $time);
      end
   endtask

   task automatic run_slot(input string nm);
      exp_t e;
      for (int k = 1; k <= SD; k++) begin
         @(posedge clk);
         #1;
         if (k < SD) begin
            check_out({nm, "_hold"}, prev);
         end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty at tick, want an expectation", nm);
         end else begin
            e = sb.pop_front();
            check_out(nm, e);
            prev = e;
         end
      end
   endtask

   // Drive one frame's inputs, queue its slot expectations and step through nslots slots.
   task automatic run_frame(input string nm, input vec_t v, input bit blank,
                            input int chg_slot, input logic [3:0] chg_su, input int nslots);
      dif.min_tens = v.mt;
      dif.min_unit = v.mu;
      dif.sec_tens = v.st;
      dif.sec_unit = v.su;
      sb.push_back('{blank ? 4'b1111 : 4'b1110, v.s_su, 1'b1, !blank});
      sb.push_back('{blank ? 4'b1111 : 4'b1101, v.s_st, 1'b1, !blank});
      sb.push_back('{blank ? 4'b1111 : 4'b1011, v.s_mu, blank, !blank});
      sb.push_back('{blank ? 4'b1111 : 4'b0111, v.s_mt, 1'b1, !blank});
      for (int s = 0; s < nslots; s++) begin
         run_slot($sformatf("%s_idx%0d", nm, s));
         if (s == chg_slot) dif.sec_unit = chg_su;
      end
   endtask

   initial begin
      bit pat[7];
      pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      blank_e = '{4'b1111, 7'b1111111, 1'b1, 1'b1};
      vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
      vecs[1] = '{4'd9, 4'd8, 4'd7, 4'd6, 7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010};
      vecs[2] = '{4'd0, 4'd5, 4'd0, 4'd0, 7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
      vecs[3] = '{4'hC, 4'hF, 4'hA, 4'hB, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      vecs[4] = '{4'd1, 4'd2, 4'd3, 4'd5, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0010010};

      // Reset and startup
      dif.finished = 1'b0;
      dif.min_tens = 4'd1;
      dif.min_unit = 4'd2;
      dif.sec_tens = 4'd3;
      dif.sec_unit = 4'd4;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_out("reset", blank_e);
      end
      rst = 1'b0;
      prev = blank_e;

      // Full scan, distinct digit patterns and invalid BCD
      for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, -1, 4'd0, 4);

      // Anti-tearing: sec_unit 4 -> 5 while idx = 1
      run_frame("tear_a", vecs[0], 1'b0, 1, 4'd5, 4);
      run_frame("tear_b", vecs[4], 1'b0, -1, 4'd0, 4);

      // Blink with finished held high, then dropped
      dif.finished = 1'b1;
      for (int f = 0; f < 7; f++)
         run_frame($sformatf("blink%0d", f + 1), vecs[f % 5], BLINK && pat[f], -1, 4'd0, 4);
      dif.finished = 1'b0;
      run_frame("unblink8", vecs[1], 1'b0, -1, 4'd0, 4);
      run_frame("unblink9", vecs[2], 1'b0, -1, 4'd0, 4);

      // Mid-frame reset while idx = 2 in a blanked frame
      dif.finished = 1'b1;
      run_frame("reblink10", vecs[0], 1'b0, -1, 4'd0, 4);
      run_frame("reblink11", vecs[1], 1'b0, -1, 4'd0, 4);
      run_frame("reblink12", vecs[2], BLINK, -1, 4'd0, 3);
      @(posedge clk);
      #1;
      check_out("pre_rst_hold", prev);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_out("midrst_blank", blank_e);
      rst = 1'b0;
      sb.delete();
      prev = blank_e;
      for (int f = 0; f < 3; f++)
         run_frame($sformatf("post_rst%0d", f + 1), vecs[f], BLINK && pat[f], -1, 4'd0, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
